// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scan driver with frame-atomic updates
// Shadow regs take new digits; the display copy only changes at frame boundaries or when idle.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ZERO_BLANK   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [0:6]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
    localparam logic [6:0]    SEG_ZERO = 7'b0000001;
    localparam logic [6:0]    SEG_DARK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                     state, n_state;
    logic [CW-1:0]              cnt, n_cnt;
    logic [IW-1:0]              idx, n_idx;
    logic [NUM_DIGITS-1:0][6:0] shadow, n_shadow;
    logic [NUM_DIGITS-1:0][6:0] disp, n_disp;
    logic [NUM_DIGITS-1:0]      shadow_dp, n_shadow_dp;
    logic [NUM_DIGITS-1:0]      disp_dp, n_disp_dp;
    logic                       pending, n_pending;
    logic                       boundary;
    logic                       run;
    logic [NUM_DIGITS-1:0]      lead_zero;
    logic [NUM_DIGITS-1:0]      n_an;
    logic [6:0]                 n_seg;
    logic                       n_dp;
    logic                       n_frame_done;

    always_comb begin
        n_state     = state;
        n_cnt       = cnt;
        n_idx       = idx;
        n_shadow    = shadow;
        n_shadow_dp = shadow_dp;
        n_disp      = disp;
        n_disp_dp   = disp_dp;
        n_pending   = pending;
        boundary    = 1'b0;
        if (state == IDLE) begin
            // Nothing is lit, so a load can go straight to the display copy.
            if (load) begin
                n_shadow    = seg_in;
                n_shadow_dp = dp_in;
                n_disp      = seg_in;
                n_disp_dp   = dp_in;
            end
            if (enable) begin
                n_state = BLANK;
                n_cnt   = '0;
                n_idx   = '0;
            end
        end else if (!enable) begin
            n_state   = IDLE;
            n_cnt     = '0;
            n_idx     = '0;
            n_pending = 1'b0;
            if (pending) begin
                n_disp    = shadow;
                n_disp_dp = shadow_dp;
            end
            if (load) begin
                n_shadow    = seg_in;
                n_shadow_dp = dp_in;
                n_disp      = seg_in;
                n_disp_dp   = dp_in;
            end
        end else begin
            boundary = (cnt == CNT_LAST) && (idx == IDX_LAST);
            if (cnt == CNT_LAST) begin
                n_cnt = '0;
                n_idx = (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                n_cnt = cnt + CW'(1);
            end
            n_state = (n_cnt < CNT_SHOW) ? BLANK : SHOW;
            // Commit reads the pre-edge shadow; a load in the same cycle waits a frame.
            if (boundary && pending) begin
                n_disp    = shadow;
                n_disp_dp = shadow_dp;
                n_pending = 1'b0;
            end
            if (load) begin
                n_shadow    = seg_in;
                n_shadow_dp = dp_in;
                n_pending   = 1'b1;
            end
        end
    end

    // A digit is a leading zero only if it and every higher digit show a bare "0".
    always_comb begin
        lead_zero = '0;
        run       = ZERO_BLANK;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run          = run && (n_disp[i] == SEG_ZERO) && !n_disp_dp[i];
            lead_zero[i] = run;
        end
    end

    always_comb begin
        n_an  = '1;
        n_seg = SEG_DARK;
        n_dp  = 1'b1;
        if (n_state == SHOW && !lead_zero[n_idx]) begin
            n_an[n_idx] = 1'b0;
            n_seg       = n_disp[n_idx];
            n_dp        = ~n_disp_dp[n_idx];
        end
        n_frame_done = (n_state != IDLE) && (n_cnt == CNT_LAST) && (n_idx == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shadow     <= {NUM_DIGITS{SEG_DARK}};
            shadow_dp  <= '0;
            disp       <= {NUM_DIGITS{SEG_DARK}};
            disp_dp    <= '0;
            pending    <= 1'b0;
            seg        <= SEG_DARK;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= n_state;
            cnt        <= n_cnt;
            idx        <= n_idx;
            shadow     <= n_shadow;
            shadow_dp  <= n_shadow_dp;
            disp       <= n_disp;
            disp_dp    <= n_disp_dp;
            pending    <= n_pending;
            seg        <= n_seg;
            dp         <= n_dp;
            an         <= n_an;
            frame_done <= n_frame_done;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
// Cycle g counts negedges after enable is sampled; frame position is derived from g.
module tb_seg7_scan_driver;
    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] P9 = 7'b0000100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [27:0] seg_in = '0;
    logic [3:0]  dp_in = '0;
    logic [0:6]  seg, seg_nz;
    logic        dp, dp_nz;
    logic [3:0]  an, an_nz;
    logic        frame_done, fd_nz;

    int errors = 0;
    int checks = 0;

    seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2), .ZERO_BLANK(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .seg_in(seg_in), .dp_in(dp_in),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2), .ZERO_BLANK(1'b0)) u_dut_nz (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .seg_in(seg_in), .dp_in(dp_in),
        .seg(seg_nz), .dp(dp_nz), .an(an_nz), .frame_done(fd_nz)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_an(input int g, input logic [3:0] lit);
        int s, c;
        s = ((g - 1) / 8) % 4;
        c = (g - 1) % 8;
        if (c >= 2 && lit[s]) return ~(4'b0001 << s);
        return 4'b1111;
    endfunction

    function automatic logic [6:0] m_seg(input int g, input logic [3:0] lit, input logic [3:0][6:0] p);
        int s;
        s = ((g - 1) / 8) % 4;
        if (m_an(g, lit) != 4'b1111) return p[s];
        return 7'b1111111;
    endfunction

    function automatic logic m_dp(input int g, input logic [3:0] lit, input logic [3:0] d);
        int s;
        s = ((g - 1) / 8) % 4;
        if (m_an(g, lit) != 4'b1111 && d[s]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        enable = 1'b0;
        load   = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start(input logic [3:0][6:0] p, input logic [3:0] d);
        seg_in = p;
        dp_in  = d;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0][6:0] p;
        @(negedge clk);
        @(negedge clk);
        checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b want 1111111", seg); end
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", an); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
        rst_n = 1'b1;
        @(negedge clk);
        p = {P4, P3, P2, P1};
        start(p, 4'b0000);
        for (int g = 1; g <= 12; g++) @(negedge clk);
        checks++; if (an !== 4'b1101) begin errors++; $display("FAIL prereset_an got %b want 1101", an); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL async_seg got %b want 1111111", seg); end
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL async_an got %b want 1111", an); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL async_dp got %b want 1", dp); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL async_fd got %b want 0", frame_done); end
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL hold_an got %b want 1111", an); end
        enable = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL idle_an got %b want 1111", an); end
    endtask

    task automatic test_scan();
        logic [3:0][6:0] p;
        logic [3:0]      d;
        do_reset();
        p = {P4, P3, P2, P1};
        d = 4'b0010;
        start(p, d);
        for (int g = 1; g <= 32; g++) begin
            @(negedge clk);
            checks++; if (an !== m_an(g, 4'hf)) begin errors++; $display("FAIL scan_an g=%0d got %b want %b", g, an, m_an(g, 4'hf)); end
            checks++; if (seg !== m_seg(g, 4'hf, p)) begin errors++; $display("FAIL scan_seg g=%0d got %b want %b", g, seg, m_seg(g, 4'hf, p)); end
            checks++; if (dp !== m_dp(g, 4'hf, d)) begin errors++; $display("FAIL scan_dp g=%0d got %b want %b", g, dp, m_dp(g, 4'hf, d)); end
            checks++; if (frame_done !== (g == 32)) begin errors++; $display("FAIL scan_fd g=%0d got %b want %b", g, frame_done, g == 32); end
        end
    endtask

    task automatic test_zero_blank();
        logic [3:0][6:0] p [3];
        logic [3:0]      lit [3];
        p[0] = {P0, P0, P0, P5}; lit[0] = 4'b0001;
        p[1] = {P0, P0, P0, P0}; lit[1] = 4'b0001;
        p[2] = {P0, P5, P0, P1}; lit[2] = 4'b0111;
        do_reset();
        for (int t = 0; t < 3; t++) begin
            start(p[t], 4'b0000);
            for (int g = 1; g <= 32; g++) begin
                @(negedge clk);
                checks++; if (an !== m_an(g, lit[t])) begin errors++; $display("FAIL zb_an t=%0d g=%0d got %b want %b", t, g, an, m_an(g, lit[t])); end
                checks++; if (seg !== m_seg(g, lit[t], p[t])) begin errors++; $display("FAIL zb_seg t=%0d g=%0d got %b want %b", t, g, seg, m_seg(g, lit[t], p[t])); end
                checks++; if (an_nz !== m_an(g, 4'hf)) begin errors++; $display("FAIL nz_an t=%0d g=%0d got %b want %b", t, g, an_nz, m_an(g, 4'hf)); end
                checks++; if (seg_nz !== m_seg(g, 4'hf, p[t])) begin errors++; $display("FAIL nz_seg t=%0d g=%0d got %b want %b", t, g, seg_nz, m_seg(g, 4'hf, p[t])); end
            end
            enable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_midframe_load();
        logic [3:0][6:0] po, pn, pe;
        do_reset();
        po = {P4, P3, P2, P1};
        pn = {P4, P3, P2, P9};
        start(po, 4'b0000);
        for (int g = 1; g <= 64; g++) begin
            @(negedge clk);
            if (g == 5) load = 1'b0;
            pe = (g <= 32) ? po : pn;
            checks++; if (an !== m_an(g, 4'hf)) begin errors++; $display("FAIL mid_an g=%0d got %b want %b", g, an, m_an(g, 4'hf)); end
            checks++; if (seg !== m_seg(g, 4'hf, pe)) begin errors++; $display("FAIL mid_seg g=%0d got %b want %b", g, seg, m_seg(g, 4'hf, pe)); end
            checks++; if (frame_done !== (g % 32 == 0)) begin errors++; $display("FAIL mid_fd g=%0d got %b want %b", g, frame_done, g % 32 == 0); end
            if (g == 4) begin
                seg_in = pn;
                load   = 1'b1;
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [3:0][6:0] po, pn, pe;
        do_reset();
        po = {P4, P3, P2, P1};
        pn = {P4, P3, P2, P7};
        start(po, 4'b0000);
        for (int g = 1; g <= 96; g++) begin
            @(negedge clk);
            if (g == 33) load = 1'b0;
            pe = (g <= 64) ? po : pn;
            checks++; if (an !== m_an(g, 4'hf)) begin errors++; $display("FAIL bnd_an g=%0d got %b want %b", g, an, m_an(g, 4'hf)); end
            checks++; if (seg !== m_seg(g, 4'hf, pe)) begin errors++; $display("FAIL bnd_seg g=%0d got %b want %b", g, seg, m_seg(g, 4'hf, pe)); end
            checks++; if (frame_done !== (g % 32 == 0)) begin errors++; $display("FAIL bnd_fd g=%0d got %b want %b", g, frame_done, g % 32 == 0); end
            if (g == 32) begin
                seg_in = pn;
                load   = 1'b1;
            end
        end
    endtask

    task automatic test_disable();
        logic [3:0][6:0] po, pn;
        do_reset();
        po = {P4, P3, P2, P1};
        pn = {P4, P3, P2, P9};
        start(po, 4'b0000);
        for (int g = 1; g <= 20; g++) begin
            @(negedge clk);
            if (g == 11) load = 1'b0;
            checks++; if (seg !== m_seg(g, 4'hf, po)) begin errors++; $display("FAIL dis_pre_seg g=%0d got %b want %b", g, seg, m_seg(g, 4'hf, po)); end
            if (g == 10) begin
                seg_in = pn;
                load   = 1'b1;
            end
        end
        enable = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++; if (an !== 4'b1111) begin errors++; $display("FAIL dis_an i=%0d got %b want 1111", i, an); end
            checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL dis_seg i=%0d got %b want 1111111", i, seg); end
            checks++; if (dp !== 1'b1) begin errors++; $display("FAIL dis_dp i=%0d got %b want 1", i, dp); end
        end
        enable = 1'b1;
        for (int h = 1; h <= 10; h++) begin
            @(negedge clk);
            checks++; if (an !== m_an(h, 4'hf)) begin errors++; $display("FAIL reen_an h=%0d got %b want %b", h, an, m_an(h, 4'hf)); end
            checks++; if (seg !== m_seg(h, 4'hf, pn)) begin errors++; $display("FAIL reen_seg h=%0d got %b want %b", h, seg, m_seg(h, 4'hf, pn)); end
            checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reen_fd h=%0d got %b want 0", h, frame_done); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_zero_blank();
        test_midframe_load();
        test_boundary_load();
        test_disable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule
